// File: rtl/game_pkg.sv
// Shared types and widths for the mental-math game round control.
package game_pkg;

   localparam int DIGIT_W     = 4;
   localparam int ROUND_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      RUN     = 3'd2,
      PAUSED  = 3'd3,
      EXPIRED = 3'd4,
      DONE    = 3'd5
   } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 while enabled, flags the last count.
module tick_prescaler #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tc
);

   localparam int               CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // next count: clear wins, otherwise advance and wrap while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   // terminal count only when this cycle actually advances the counter
   assign tc = enable && !clear && (cnt_q == LAST);

   // count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/round_tick_ctrl.sv
// Round control for the two-digit countdown: loads the round time, issues
// decrement ticks, ends the round on time-out or answer, keeps round stats.
module round_tick_ctrl
   import game_pkg::*;
#(
   parameter int               TICK_DIV    = 50000000,
   parameter logic [DIGIT_W-1:0] ROUND_TENS  = 4'd6,
   parameter logic [DIGIT_W-1:0] ROUND_UNITS = 4'd0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   pause,
   input  logic                   answer_valid,
   input  logic [DIGIT_W-1:0]     digit_tens,
   input  logic [DIGIT_W-1:0]     digit_units,
   output logic                   reconfig,
   output logic [DIGIT_W-1:0]     setDigit_tens,
   output logic [DIGIT_W-1:0]     setDigit_units,
   output logic                   decrement,
   output logic                   running,
   output logic                   time_up,
   output logic                   answered,
   output logic [DIGIT_W-1:0]     time_left_tens,
   output logic [DIGIT_W-1:0]     time_left_units,
   output logic [ROUND_CNT_W-1:0] round_count
);

   state_e                 state_q, state_d;
   logic                   reconfig_q, reconfig_d;
   logic                   decrement_q, decrement_d;
   logic                   running_q, running_d;
   logic                   time_up_q, time_up_d;
   logic                   answered_q, answered_d;
   logic [DIGIT_W-1:0]     tl_tens_q, tl_tens_d;
   logic [DIGIT_W-1:0]     tl_units_q, tl_units_d;
   logic [ROUND_CNT_W-1:0] round_cnt_q, round_cnt_d;

   logic zero, presc_en, presc_clr, tick, round_end;

   assign zero = (digit_tens == '0) && (digit_units == '0);

   // next state: RUN priority is zero, then answer, then pause
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:          if (start) state_d = LOAD;
         LOAD:          state_d = RUN;
         RUN: begin
            if (zero)              state_d = EXPIRED;
            else if (answer_valid) state_d = DONE;
            else if (pause)        state_d = PAUSED;
         end
         PAUSED: begin
            if (answer_valid)      state_d = DONE;
            else if (!pause)       state_d = RUN;
         end
         EXPIRED, DONE: if (start) state_d = LOAD;
         default:       state_d = IDLE;
      endcase
   end

   // prescaler only advances on RUN cycles that stay in RUN, so a tick can
   // never be registered on the way out of RUN
   assign presc_en  = (state_q == RUN) && (state_d == RUN);
   assign presc_clr = (state_d == LOAD);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk    (clk),
      .reset  (reset),
      .enable (presc_en),
      .clear  (presc_clr),
      .tc     (tick)
   );

   assign round_end = ((state_d == EXPIRED) || (state_d == DONE)) && (state_d != state_q);

   // registered outputs are decoded from the next state so they line up with it
   always_comb begin
      reconfig_d  = (state_d == LOAD);
      decrement_d = tick;
      running_d   = (state_d == RUN) || (state_d == PAUSED);
      time_up_d   = (state_d == EXPIRED);
      answered_d  = (state_d == DONE);
      tl_tens_d   = tl_tens_q;
      tl_units_d  = tl_units_q;
      round_cnt_d = round_cnt_q;
      if ((state_d == DONE) && (state_q != DONE)) begin
         tl_tens_d  = digit_tens;
         tl_units_d = digit_units;
      end
      if (round_end && (round_cnt_q != '1))
         round_cnt_d = round_cnt_q + 1'b1;
   end

   // state and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         reconfig_q  <= 1'b0;
         decrement_q <= 1'b0;
         running_q   <= 1'b0;
         time_up_q   <= 1'b0;
         answered_q  <= 1'b0;
         tl_tens_q   <= '0;
         tl_units_q  <= '0;
         round_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         reconfig_q  <= reconfig_d;
         decrement_q <= decrement_d;
         running_q   <= running_d;
         time_up_q   <= time_up_d;
         answered_q  <= answered_d;
         tl_tens_q   <= tl_tens_d;
         tl_units_q  <= tl_units_d;
         round_cnt_q <= round_cnt_d;
      end
   end

   assign reconfig        = reconfig_q;
   assign decrement       = decrement_q;
   assign running         = running_q;
   assign time_up         = time_up_q;
   assign answered        = answered_q;
   assign time_left_tens  = tl_tens_q;
   assign time_left_units = tl_units_q;
   assign round_count     = round_cnt_q;
   assign setDigit_tens   = ROUND_TENS;
   assign setDigit_units  = ROUND_UNITS;

endmodule

// File: tb/tb_round_tick_ctrl.sv
// Bench for round_tick_ctrl with a behavioural countdown in the loop.
module tb_round_tick_ctrl;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       reset, start, pause, answer_valid;
   logic [3:0] cd_t, cd_u;
   logic       reconfig, decrement, running, time_up, answered;
   logic [3:0] set_t, set_u, tl_t, tl_u;
   logic [7:0] round_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   round_tick_ctrl #(.TICK_DIV(TD), .ROUND_TENS(4'd0), .ROUND_UNITS(4'd3)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .pause           (pause),
      .answer_valid    (answer_valid),
      .digit_tens      (cd_t),
      .digit_units     (cd_u),
      .reconfig        (reconfig),
      .setDigit_tens   (set_t),
      .setDigit_units  (set_u),
      .decrement       (decrement),
      .running         (running),
      .time_up         (time_up),
      .answered        (answered),
      .time_left_tens  (tl_t),
      .time_left_units (tl_u),
      .round_count     (round_count)
   );

   // behavioural BCD countdown fed back to the controller
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cd_t <= 4'd0;
         cd_u <= 4'd0;
      end else if (reconfig) begin
         cd_t <= set_t;
         cd_u <= set_u;
      end else if (decrement) begin
         if (cd_u != 4'd0) cd_u <= cd_u - 4'd1;
         else if (cd_t != 4'd0) begin
            cd_t <= cd_t - 4'd1;
            cd_u <= 4'd9;
         end
      end
   end

   // reference model: round phase tracked by flags, ticks by counting the
   // cycles the round actually advanced since the load
   logic m_reconfig, m_dec, m_running, m_paused, m_time_up, m_answered;
   logic [3:0] m_tl_t, m_tl_u;
   int   m_cnt, m_adv;
   logic m_zero;
   assign m_zero = (cd_t == 4'd0) && (cd_u == 4'd0);

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_reconfig <= 0; m_dec <= 0; m_running <= 0; m_paused <= 0;
         m_time_up <= 0; m_answered <= 0; m_tl_t <= 0; m_tl_u <= 0;
         m_cnt <= 0; m_adv <= 0;
      end else begin
         m_reconfig <= 0;
         m_dec      <= 0;
         if (m_reconfig) begin
            m_running <= 1; m_paused <= 0; m_adv <= 0;
         end else if (m_running && !m_paused) begin
            if (m_zero) begin
               m_running <= 0; m_time_up <= 1; m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
            end else if (answer_valid) begin
               m_running <= 0; m_answered <= 1; m_tl_t <= cd_t; m_tl_u <= cd_u;
               m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
            end else if (pause) begin
               m_paused <= 1;
            end else begin
               m_adv <= m_adv + 1;
               if ((m_adv + 1) % TD == 0) m_dec <= 1;
            end
         end else if (m_running) begin
            if (answer_valid) begin
               m_running <= 0; m_answered <= 1; m_tl_t <= cd_t; m_tl_u <= cd_u;
               m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
            end else if (!pause) m_paused <= 0;
         end else if (start) begin
            m_reconfig <= 1; m_time_up <= 0; m_answered <= 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [20:0] dut_vec();
      return {reconfig, decrement, running, time_up, answered, tl_t, tl_u, round_count};
   endfunction

   typedef struct {
      logic       start;
      logic [3:0] exp;   // {reconfig, decrement, running, time_up}
      logic [7:0] dig;   // {tens, units}
   } vec_t;
   vec_t tbl[18];

   initial begin
      int   lat;
      logic seen;
      tbl[0]  = '{1'b1, 4'b0000, 8'h00};
      tbl[1]  = '{1'b0, 4'b1000, 8'h00};
      tbl[2]  = '{1'b0, 4'b0010, 8'h03};
      tbl[3]  = '{1'b0, 4'b0010, 8'h03};
      tbl[4]  = '{1'b0, 4'b0010, 8'h03};
      tbl[5]  = '{1'b0, 4'b0010, 8'h03};
      tbl[6]  = '{1'b0, 4'b0110, 8'h03};
      tbl[7]  = '{1'b0, 4'b0010, 8'h02};
      tbl[8]  = '{1'b0, 4'b0010, 8'h02};
      tbl[9]  = '{1'b0, 4'b0010, 8'h02};
      tbl[10] = '{1'b0, 4'b0110, 8'h02};
      tbl[11] = '{1'b0, 4'b0010, 8'h01};
      tbl[12] = '{1'b0, 4'b0010, 8'h01};
      tbl[13] = '{1'b0, 4'b0010, 8'h01};
      tbl[14] = '{1'b0, 4'b0110, 8'h01};
      tbl[15] = '{1'b0, 4'b0010, 8'h00};
      tbl[16] = '{1'b0, 4'b0001, 8'h00};
      tbl[17] = '{1'b0, 4'b0001, 8'h00};

      reset = 1; start = 0; pause = 0; answer_valid = 0;
      repeat (3) step();
      chk("reset_hold", 32'(dut_vec()), 32'd0);
      chk("set_digits", {24'd0, set_t, set_u}, 32'h03);
      reset = 0;

      // idle after reset: nothing moves without start
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle", 32'(dut_vec()), 32'd0);
      end

      // basic round, cycle by cycle
      for (int i = 0; i < 18; i++) begin
         start = tbl[i].start;
         chk($sformatf("round_row%0d", i), {28'd0, reconfig, decrement, running, time_up}, {28'd0, tbl[i].exp});
         chk($sformatf("digits_row%0d", i), {24'd0, cd_t, cd_u}, {24'd0, tbl[i].dig});
         step();
      end
      start = 0;
      chk("count_after_expiry", {24'd0, round_count}, 32'd1);

      // pause two RUN cycles after LOAD, for 10 cycles
      start = 1; step(); start = 0;
      chk("pause_load", {31'd0, reconfig}, 32'd1);
      step(); step(); step();
      pause = 1;
      for (int i = 0; i < 10; i++) begin
         chk("pause_hold", {30'd0, running, decrement}, 32'b10);
         step();
      end
      pause = 0;
      lat = -1;
      for (int n = 0; n < 12 && lat < 0; n++) begin
         chk("pause_resume_run", {31'd0, running}, 32'd1);
         if (decrement) lat = n;
         else step();
      end
      chk("pause_resume_lat", 32'(lat), 32'd3);

      // answer while digits read 02
      step();
      chk("answer_digits", {24'd0, cd_t, cd_u}, 32'h02);
      answer_valid = 1; step(); answer_valid = 0;
      chk("answer_done", {28'd0, running, answered, time_up, reconfig}, 32'b0100);
      chk("answer_latch", {24'd0, tl_t, tl_u}, 32'h02);
      chk("answer_count", {24'd0, round_count}, 32'd2);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (decrement || !answered) seen = 1;
      end
      chk("done_quiet", {31'd0, seen}, 32'd0);
      start = 1; step(); start = 0;
      chk("restart_from_done", {31'd0, reconfig}, 32'd1);
      chk("restart_count", {24'd0, round_count}, 32'd2);

      // answer in the very cycle the digits reach 00: time-out wins
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         if (running && cd_t == 0 && cd_u == 0) seen = 1;
      end
      chk("zero_reached", {31'd0, seen}, 32'd1);
      answer_valid = 1; step(); answer_valid = 0;
      chk("zero_vs_answer", {30'd0, time_up, answered}, 32'b10);
      chk("zero_keep_latch", {24'd0, tl_t, tl_u}, 32'h02);
      chk("zero_count", {24'd0, round_count}, 32'd3);

      // start ignored mid-RUN, then asynchronous reset mid-RUN
      start = 1; step(); start = 0;
      step(); step();
      start = 1; step(); start = 0;
      chk("start_in_run", {30'd0, reconfig, running}, 32'b01);
      #3 reset = 1;
      #1 chk("async_reset", 32'(dut_vec()), 32'd0);
      step(); step();
      reset = 0;

      // randomised traffic against the reference model
      for (int i = 0; i < 1500; i++) begin
         start        = ($urandom_range(0, 7) == 0);
         answer_valid = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) == 0) pause = ~pause;
         step();
         chk("rand", 32'(dut_vec()),
             32'({m_reconfig, m_dec, m_running, m_time_up, m_answered, m_tl_t, m_tl_u, 8'(m_cnt)}));
      end

      // round counter saturation
      start = 0; pause = 0; answer_valid = 0;
      repeat (30) step();
      for (int i = 0; i < 300; i++) begin
         start = 1; step(); start = 0; step();
         answer_valid = 1; step(); answer_valid = 0; step();
      end
      chk("count_saturate", {24'd0, round_count}, 32'd255);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
